// File: rtl/input_debounce_if.sv
// Board-pin conditioning bundle: raw KEY/SW pins in, debounced levels and press events out.
interface input_debounce_if #(
   parameter int NUM_BUTTONS  = 2,
   parameter int NUM_SWITCHES = 10
);
   logic [NUM_BUTTONS-1:0]  button_raw_n;
   logic [NUM_SWITCHES-1:0] switch_raw;
   logic [NUM_BUTTONS-1:0]  button_db_n;
   logic [NUM_SWITCHES-1:0] switch_db;
   logic [NUM_BUTTONS-1:0]  button_press;
   logic [NUM_BUTTONS-1:0]  button_long;

   modport master (
      output button_raw_n, switch_raw,
      input  button_db_n, switch_db, button_press, button_long
   );

   modport slave (
      input  button_raw_n, switch_raw,
      output button_db_n, switch_db, button_press, button_long
   );
endinterface

// File: rtl/input_debounce.sv
// Per-bit two-flop sync + counter debounce for DE10-Lite KEY/SW, with press pulses.
// Optional long-press flags are built when INPUT_DEBOUNCE_LONG_PRESS_EN is defined.
module input_debounce #(
   parameter int NUM_BUTTONS     = 2,
   parameter int NUM_SWITCHES    = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input_debounce_if.slave   io
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
      $error("input_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
   end

   logic [NUM_BUTTONS-1:0]  btn_s1, btn_s2, btn_db, btn_accept, btn_db_next, btn_press;
   logic [NUM_SWITCHES-1:0] sw_s1, sw_s2, sw_db, sw_accept;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         btn_s1 <= '1;
         btn_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= io.button_raw_n;
         btn_s2 <= btn_s1;
         sw_s1  <= io.switch_raw;
         sw_s2  <= sw_s1;
      end
   end

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      logic [CW-1:0] cnt;

      assign btn_accept[i] = (btn_s2[i] != btn_db[i]) && (cnt == DB_TC);

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n)               cnt <= '0;
         else if (btn_s2[i] == btn_db[i])  cnt <= '0;
         else if (cnt == DB_TC)            cnt <= '0;
         else                              cnt <= cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
      logic [CW-1:0] cnt;

      assign sw_accept[i] = (sw_s2[i] != sw_db[i]) && (cnt == DB_TC);

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n)             cnt <= '0;
         else if (sw_s2[i] == sw_db[i])  cnt <= '0;
         else if (cnt == DB_TC)          cnt <= '0;
         else                            cnt <= cnt + 1'b1;
      end
   end

   // An accepted change always flips db, so next-state is a simple toggle.
   assign btn_db_next = btn_db ^ btn_accept;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         btn_db    <= '1;
         sw_db     <= '0;
         btn_press <= '0;
      end else begin
         btn_db    <= btn_db_next;
         sw_db     <= sw_db ^ sw_accept;
         btn_press <= btn_db & ~btn_db_next;
      end
   end

   assign io.button_db_n  = btn_db;
   assign io.switch_db    = sw_db;
   assign io.button_press = btn_press;

`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_TC  = LW'(LONG_CYCLES - 1);

   logic [NUM_BUTTONS-1:0] btn_long;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_long
      logic [LW-1:0] hold;

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            hold        <= '0;
            btn_long[i] <= 1'b0;
         end else begin
            if (btn_db[i])              hold <= '0;
            else if (hold != LONG_MAX)  hold <= hold + 1'b1;
            // Clear on the very edge the debounced button releases.
            if (btn_db_next[i])                   btn_long[i] <= 1'b0;
            else if (!btn_db[i] && hold == LONG_TC) btn_long[i] <= 1'b1;
         end
      end
   end

   assign io.button_long = btn_long;
`else
   assign io.button_long = '0;
`endif
endmodule
